// File: rtl/register_bank.sv
// register_bank
//
// Parametrised bank of NREG general-purpose registers, each WIDTH bits wide.
// Every register whose RegSel bit is high applies the same FunSel operation to
// its own current value on the rising Clock edge. Two combinational read
// ports and a per-register zero flag expose the current state. Each register
// also keeps a sticky overflow flag that records boundary inc/dec events.
//
// Parameters
//   WIDTH    register width in bits (even, >= 8)
//   NREG     number of registers (>= 2)
//   SATURATE 0 = inc/dec wrap modulo 2^WIDTH, 1 = inc/dec clamp at bounds
//
// Ports
//   Clock    in   1      rising-edge clock
//   Reset    in   1      asynchronous, active-low; clears all state
//   I        in   WIDTH  write data
//   RegSel   in   NREG   enable mask, bit k enables register k
//   FunSel   in   3      operation applied to every enabled register
//   OutASel  in   SELW   read port A index
//   OutBSel  in   SELW   read port B index
//   OutA     out  WIDTH  contents of register OutASel (0 if index >= NREG)
//   OutB     out  WIDTH  contents of register OutBSel (0 if index >= NREG)
//   Ovf      out  NREG   sticky overflow flag per register
//   Zero     out  NREG   bit k high when register k equals 0
//
// FunSel
//   000 dec   001 inc   010 load   011 clear
//   100 low load zero-extend   101 low-half write
//   110 high-half write        111 low load sign-extend
module register_bank #(
  parameter int WIDTH    = 16,
  parameter int NREG     = 4,
  parameter int SATURATE = 0,
  localparam int HALF    = WIDTH / 2,
  localparam int SELW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [WIDTH-1:0]  I,
  input  logic [NREG-1:0]   RegSel,
  input  logic [2:0]        FunSel,
  input  logic [SELW-1:0]   OutASel,
  input  logic [SELW-1:0]   OutBSel,
  output logic [WIDTH-1:0]  OutA,
  output logic [WIDTH-1:0]  OutB,
  output logic [NREG-1:0]   Ovf,
  output logic [NREG-1:0]   Zero
);

  localparam logic [2:0] FS_DEC    = 3'b000;
  localparam logic [2:0] FS_INC    = 3'b001;
  localparam logic [2:0] FS_LOAD   = 3'b010;
  localparam logic [2:0] FS_CLEAR  = 3'b011;
  localparam logic [2:0] FS_LOZX   = 3'b100;
  localparam logic [2:0] FS_LOWR   = 3'b101;
  localparam logic [2:0] FS_HIWR   = 3'b110;
  localparam logic [2:0] FS_LOSX   = 3'b111;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  // Flat view of every register so the read ports can index by a variable.
  logic [WIDTH-1:0] reg_view [NREG];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      logic [WIDTH-1:0] value_reg;
      logic [WIDTH-1:0] value_next;
      logic             ovf_reg;
      logic             ovf_next;

      always_comb begin
        value_next = value_reg;
        ovf_next   = ovf_reg;
        case (FunSel)
          FS_DEC: begin
            if (value_reg == '0) begin
              ovf_next   = 1'b1;
              value_next = (SATURATE != 0) ? '0 : ALL_ONES;
            end else begin
              value_next = value_reg - ONE;
            end
          end
          FS_INC: begin
            if (value_reg == ALL_ONES) begin
              ovf_next   = 1'b1;
              value_next = (SATURATE != 0) ? ALL_ONES : '0;
            end else begin
              value_next = value_reg + ONE;
            end
          end
          FS_LOAD: begin
            value_next = I;
            ovf_next   = 1'b0;
          end
          FS_CLEAR: begin
            value_next = '0;
            ovf_next   = 1'b0;
          end
          FS_LOZX: begin
            value_next = {{HALF{1'b0}}, I[HALF-1:0]};
            ovf_next   = 1'b0;
          end
          // Half-word writes leave the overflow history untouched.
          FS_LOWR: value_next = {value_reg[WIDTH-1:HALF], I[HALF-1:0]};
          FS_HIWR: value_next = {I[HALF-1:0], value_reg[HALF-1:0]};
          FS_LOSX: begin
            value_next = {{HALF{I[HALF-1]}}, I[HALF-1:0]};
            ovf_next   = 1'b0;
          end
          default: begin
            value_next = value_reg;
            ovf_next   = ovf_reg;
          end
        endcase
      end

      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          value_reg <= '0;
          ovf_reg   <= 1'b0;
        end else if (RegSel[gi]) begin
          value_reg <= value_next;
          ovf_reg   <= ovf_next;
        end
      end

      assign reg_view[gi] = value_reg;
      assign Ovf[gi]      = ovf_reg;
      assign Zero[gi]     = (value_reg == '0);
    end
  endgenerate

  // Indices past the last register (only reachable when NREG is not a power
  // of two) read as zero rather than aliasing onto a real register.
  localparam logic [SELW:0] NREG_IDX = (SELW + 1)'(NREG);

  assign OutA = ({1'b0, OutASel} < NREG_IDX) ? reg_view[OutASel] : '0;
  assign OutB = ({1'b0, OutBSel} < NREG_IDX) ? reg_view[OutBSel] : '0;

endmodule

// File: tb/tb_register_bank.sv
`timescale 1ns/1ps
module tb_register_bank;

  logic        Clock;
  logic        Reset;
  logic [15:0] I;
  logic [3:0]  RegSel;
  logic [2:0]  FunSel;
  logic [1:0]  OutASel;
  logic [1:0]  OutBSel;
  logic [15:0] outa_w, outb_w, outa_s, outb_s;
  logic [3:0]  ovf_w, zero_w, ovf_s, zero_s;

  int checks;
  int failures;

  register_bank #(.WIDTH(16), .NREG(4), .SATURATE(0)) dut_wrap (
    .Clock(Clock), .Reset(Reset), .I(I), .RegSel(RegSel), .FunSel(FunSel),
    .OutASel(OutASel), .OutBSel(OutBSel),
    .OutA(outa_w), .OutB(outb_w), .Ovf(ovf_w), .Zero(zero_w)
  );

  register_bank #(.WIDTH(16), .NREG(4), .SATURATE(1)) dut_sat (
    .Clock(Clock), .Reset(Reset), .I(I), .RegSel(RegSel), .FunSel(FunSel),
    .OutASel(OutASel), .OutBSel(OutBSel),
    .OutA(outa_s), .OutB(outb_s), .Ovf(ovf_s), .Zero(zero_s)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: plain integer arithmetic per register, one copy per mode.
  int unsigned mw [4];
  int unsigned ms [4];
  bit          ow [4];
  bit          os [4];

  task automatic apply_op(input int unsigned v_in, input bit o_in, input bit sat,
                          input logic [2:0] fs, input logic [15:0] din,
                          output int unsigned v_out, output bit o_out);
    int t;
    int unsigned lo;
    lo    = int'(din[7:0]);
    v_out = v_in;
    o_out = o_in;
    case (fs)
      3'd0: begin
        t = int'(v_in) - 1;
        if (t < 0) begin o_out = 1; v_out = sat ? 0 : 65535; end
        else v_out = t;
      end
      3'd1: begin
        t = int'(v_in) + 1;
        if (t > 65535) begin o_out = 1; v_out = sat ? 65535 : 0; end
        else v_out = t;
      end
      3'd2: begin v_out = int'(din); o_out = 0; end
      3'd3: begin v_out = 0; o_out = 0; end
      3'd4: begin v_out = lo; o_out = 0; end
      3'd5: v_out = (v_in / 256) * 256 + lo;
      3'd6: v_out = lo * 256 + (v_in % 256);
      3'd7: begin v_out = (lo >= 128) ? (65280 + lo) : lo; o_out = 0; end
      default: ;
    endcase
  endtask

  always @(posedge Clock) begin
    if (Reset === 1'b1) begin
      for (int k = 0; k < 4; k++) begin
        if (RegSel[k]) begin
          apply_op(mw[k], ow[k], 1'b0, FunSel, I, mw[k], ow[k]);
          apply_op(ms[k], os[k], 1'b1, FunSel, I, ms[k], os[k]);
        end
      end
    end
  end

  always @(negedge Reset) begin
    for (int k = 0; k < 4; k++) begin
      mw[k] = 0; ms[k] = 0; ow[k] = 0; os[k] = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_ovf(input bit sat);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = sat ? os[k] : ow[k];
    return r;
  endfunction

  function automatic logic [3:0] model_zero(input bit sat);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = sat ? (ms[k] == 0) : (mw[k] == 0);
    return r;
  endfunction

  // Per-cycle comparison of every output of both instances against the model.
  bit compare_en;
  always @(negedge Clock) begin
    if (compare_en) begin
      chk("wrap_OutA", 32'(outa_w), mw[OutASel]);
      chk("wrap_OutB", 32'(outb_w), mw[OutBSel]);
      chk("wrap_Ovf",  32'(ovf_w),  32'(model_ovf(1'b0)));
      chk("wrap_Zero", 32'(zero_w), 32'(model_zero(1'b0)));
      chk("sat_OutA",  32'(outa_s), ms[OutASel]);
      chk("sat_OutB",  32'(outb_s), ms[OutBSel]);
      chk("sat_Ovf",   32'(ovf_s),  32'(model_ovf(1'b1)));
      chk("sat_Zero",  32'(zero_s), 32'(model_zero(1'b1)));
    end
  end

  // Present an operation; it takes effect at the next rising edge.
  task automatic op(input logic [3:0] rs, input logic [2:0] fs, input logic [15:0] din);
    @(posedge Clock);
    #1;
    RegSel = rs;
    FunSel = fs;
    I      = din;
    $display("op   RegSel=%b FunSel=%b I=%h", rs, fs, din);
  endtask

  // Let the pending operation land, idle the bank, then read one register
  // on both ports of both instances and compare with literal expectations.
  task automatic peek(input logic [1:0] sel, input logic [15:0] exp_w, input logic [15:0] exp_s);
    @(posedge Clock);
    #1;
    RegSel  = 4'b0000;
    OutASel = sel;
    OutBSel = sel;
    #1;
    chk("lit_wrap_OutA", 32'(outa_w), 32'(exp_w));
    chk("lit_wrap_OutB", 32'(outb_w), 32'(exp_w));
    chk("lit_sat_OutA",  32'(outa_s), 32'(exp_s));
    chk("lit_sat_OutB",  32'(outb_s), 32'(exp_s));
    $display("peek R%0d wrap=%h sat=%h", sel, outa_w, outa_s);
  endtask

  task automatic flags(input logic [3:0] ew_ovf, input logic [3:0] es_ovf,
                       input logic [3:0] ew_zero, input logic [3:0] es_zero);
    chk("lit_wrap_Ovf",  32'(ovf_w),  32'(ew_ovf));
    chk("lit_sat_Ovf",   32'(ovf_s),  32'(es_ovf));
    chk("lit_wrap_Zero", 32'(zero_w), 32'(ew_zero));
    chk("lit_sat_Zero",  32'(zero_s), 32'(es_zero));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    compare_en = 1'b0;
    Reset = 1'b0;
    I = '0; RegSel = '0; FunSel = '0; OutASel = '0; OutBSel = '0;
    for (int k = 0; k < 4; k++) begin
      mw[k] = 0; ms[k] = 0; ow[k] = 0; os[k] = 0;
    end
    #1;
    compare_en = 1'b1;

    // Reset defaults; a load while in reset must not stick.
    repeat (3) @(posedge Clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      OutASel = 2'(k);
      OutBSel = 2'(3 - k);
      #0.5;
      chk("rst_OutA", 32'(outa_w), 32'h0);
      chk("rst_OutB", 32'(outb_s), 32'h0);
    end
    flags(4'b0000, 4'b0000, 4'b1111, 4'b1111);
    op(4'b0100, 3'b010, 16'h1234);
    peek(2'd2, 16'h0000, 16'h0000);
    @(negedge Clock);
    Reset = 1'b1;

    // Load and half-word modes on R1.
    op(4'b0010, 3'b010, 16'h80F0); peek(2'd1, 16'h80F0, 16'h80F0);
    op(4'b0010, 3'b110, 16'h00AB); peek(2'd1, 16'hABF0, 16'hABF0);
    op(4'b0010, 3'b101, 16'h0012); peek(2'd1, 16'hAB12, 16'hAB12);
    op(4'b0010, 3'b111, 16'h0085); peek(2'd1, 16'hFF85, 16'hFF85);
    op(4'b0010, 3'b100, 16'h0085); peek(2'd1, 16'h0085, 16'h0085);

    // Inc/dec at the upper bound on R0.
    op(4'b0001, 3'b010, 16'hFFFF);
    op(4'b0001, 3'b001, 16'h0000); peek(2'd0, 16'h0000, 16'hFFFF);
    flags(4'b0001, 4'b0001, 4'b1101, 4'b1100);
    op(4'b0001, 3'b000, 16'h0000); peek(2'd0, 16'hFFFF, 16'hFFFE);
    flags(4'b0001, 4'b0001, 4'b1100, 4'b1100);
    op(4'b0001, 3'b010, 16'h0005); peek(2'd0, 16'h0005, 16'h0005);
    flags(4'b0000, 4'b0000, 4'b1100, 4'b1100);

    // Inc/dec at both bounds on R3; half write keeps the flag.
    op(4'b1000, 3'b011, 16'h0000);
    op(4'b1000, 3'b000, 16'h0000); peek(2'd3, 16'hFFFF, 16'h0000);
    flags(4'b1000, 4'b1000, 4'b0100, 4'b1100);
    op(4'b1000, 3'b010, 16'hFFFF);
    op(4'b1000, 3'b001, 16'h0000); peek(2'd3, 16'h0000, 16'hFFFF);
    op(4'b1000, 3'b110, 16'h00AB); peek(2'd3, 16'hAB00, 16'hABFF);
    flags(4'b1000, 4'b1000, 4'b0100, 4'b0100);

    // Enable mask and shared read index.
    op(4'b0001, 3'b010, 16'd1);
    op(4'b0010, 3'b010, 16'd2);
    op(4'b0100, 3'b010, 16'd3);
    op(4'b1000, 3'b010, 16'd4);
    op(4'b0101, 3'b001, 16'd0);
    peek(2'd0, 16'd2, 16'd2);
    peek(2'd1, 16'd2, 16'd2);
    peek(2'd2, 16'd4, 16'd4);
    peek(2'd3, 16'd4, 16'd4);
    // Write cycle: the port still shows the pre-edge value.
    op(4'b0100, 3'b001, 16'd0);
    OutASel = 2'd2;
    #1;
    chk("pre_edge_wrap_OutA", 32'(outa_w), 32'd4);
    chk("pre_edge_sat_OutA",  32'(outa_s), 32'd4);
    peek(2'd2, 16'd5, 16'd5);

    // Asynchronous reset while the whole bank counts up.
    op(4'b1111, 3'b001, 16'd0);
    repeat (3) @(posedge Clock);
    #2;
    Reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      OutASel = 2'(k);
      OutBSel = 2'(3 - k);
      #0.5;
      chk("async_wrap_OutA", 32'(outa_w), 32'h0);
      chk("async_sat_OutB",  32'(outb_s), 32'h0);
    end
    flags(4'b0000, 4'b0000, 4'b1111, 4'b1111);
    #3;
    Reset = 1'b1;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    OutASel = 2'd3;
    OutBSel = 2'd0;
    #0.5;
    chk("restart_wrap_OutA", 32'(outa_w), 32'd2);
    chk("restart_sat_OutB",  32'(outb_s), 32'd2);
    RegSel = 4'b0000;

    // Randomized traffic; a rare mid-cycle reset pulse exercises the async path.
    for (int n = 0; n < 400; n++) begin
      @(posedge Clock);
      #1;
      RegSel  = 4'($urandom);
      FunSel  = 3'($urandom);
      OutASel = 2'($urandom);
      OutBSel = 2'($urandom);
      case ($urandom_range(0, 3))
        0: I = 16'hFFFF;
        1: I = 16'h0000;
        default: I = 16'($urandom);
      endcase
      $display("rand RegSel=%b FunSel=%b I=%h A=%0d B=%0d", RegSel, FunSel, I, OutASel, OutBSel);
      if ($urandom_range(0, 99) == 0) begin
        #1 Reset = 1'b0;
        #1 Reset = 1'b1;
      end
    end

    @(posedge Clock);
    #1;
    RegSel = 4'b0000;
    @(negedge Clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised bank of NREG general-purpose registers of WIDTH bits, each supporting the team's standard 3-bit FunSel operation set (inc/dec, load, clear, half-word loads, sign extension), generalised in width and register count. Adds a multi-register enable mask, two independent read ports, selectable wrap or saturate arithmetic, and a per-register sticky overflow flag. It sits between the datapath bus and the ALU operand multiplexers, replacing individually instantiated fixed 16-bit registers.

## Interface
- WIDTH, 16, register width in bits; even, minimum 8; HALF = WIDTH/2
- NREG, 4, number of registers; minimum 2; SELW = clog2(NREG)
- SATURATE, 0, 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc/dec clamp at bounds
- Clock  input  1  rising-edge clock, sole clock domain
- Reset  input  1  asynchronous, active-low; clears all state immediately
- I  input  WIDTH  write data
- RegSel  input  NREG  enable mask; bit k enables register k
- FunSel  input  3  operation applied to every enabled register
- OutASel  input  SELW  read port A register index
- OutBSel  input  SELW  read port B register index
- OutA  output  WIDTH  contents of register OutASel (combinational read)
- OutB  output  WIDTH  contents of register OutBSel (combinational read)
- Ovf  output  NREG  sticky overflow flag per register
- Zero  output  NREG  bit k high when register k equals 0 (combinational)

## Operation
- FunSel, per enabled register R (unsigned arithmetic, WIDTH bits):
  - 000 decrement: R-1
  - 001 increment: R+1
  - 010 load: R = I
  - 011 clear: R = 0
  - 100 low load, zero-extend: R = {HALF zeros, I[HALF-1:0]}
  - 101 low write: R[HALF-1:0] = I[HALF-1:0], upper half held
  - 110 high write: R[WIDTH-1:HALF] = I[HALF-1:0], lower half held
  - 111 low load, sign-extend: R = {HALF copies of I[HALF-1], I[HALF-1:0]}
- Boundaries, SATURATE=0: dec at 0 gives all-ones; inc at all-ones gives 0; Ovf[k] set.
- Boundaries, SATURATE=1: dec at 0 holds 0; inc at all-ones holds all-ones; Ovf[k] set.
- Ovf[k] is sticky: it is set only by a boundary inc/dec. It is cleared by any of FunSel 010, 011, 100 or 111 on register k. FunSel 101/110 leave it unchanged.
- Ovf set and clear never coincide: a boundary event is only an inc/dec.
- RegSel bit low: register and its Ovf bit hold.
- Multiple RegSel bits high: each enabled register applies the operation to its own current value independently. The all-ones mask with 011 is a bank-wide clear.
- RegSel all zero: no state change.
- OutASel and OutBSel may select the same register; both ports then show the same value.
- Read index at or above NREG (non-power-of-two NREG) returns 0.

## Timing
- Reset low: all registers, Ovf and outputs-derived state go to 0 asynchronously, without waiting for a clock edge.
- Reset value: OutA=OutB=0, Ovf=0, Zero=all ones.
- Reset release is sampled at the next rising Clock; the first update occurs on the first rising edge with Reset high.
- Reset asserted mid-sequence aborts any pending operation; no partial update is retained.
- All register and Ovf updates occur on the rising Clock edge; write latency is 1 cycle.
- Read ports are combinational from current register state. In the cycle of a write, a port shows the old value; the new value appears after the edge.
- There is no handshake. Inputs must be stable around the rising edge.

## Test plan
- Reset/defaults (WIDTH=16, NREG=4): hold Reset low, pulse clocks -> all OutA/OutB=0x0000, Ovf=0000, Zero=1111. Then load 0x1234 into R2 with Reset low -> R2 stays 0.
- Load and modes: R1 load I=0x80F0 (010) -> 0x80F0. Then 110 with I=0x00AB -> 0xABF0. Then 101 with I=0x0012 -> 0xAB12. Then 111 with I=0x0085 -> 0xFF85. Then 100 with I=0x0085 -> 0x0085.
- Wrap (SATURATE=0): R0=0xFFFF, inc -> 0x0000, Ovf[0]=1, Zero[0]=1. Dec -> 0xFFFF, Ovf[0] stays 1. Load 0x0005 -> Ovf[0]=0.
- Saturate (SATURATE=1): R3=0x0000, dec -> 0x0000 with Ovf[3]=1. R3=0xFFFF, inc -> 0xFFFF with Ovf[3]=1. A 110 write leaves Ovf[3]=1.
- Mask and read ports: R0..R3=1,2,3,4; RegSel=0101 with inc -> 2,2,4,4. OutASel=OutBSel=2 -> both read 4. In the write cycle OutA shows the pre-edge value.
- Async reset mid-operation: with RegSel=1111 and inc running each cycle, drop Reset between edges -> all outputs read 0 before the next edge. Release Reset -> counting restarts from 0.
